button_event_decoder: RTL
=========================

Name: button_event_decoder

Overview:
- Downstream consumer of the synchronised, debounced button level (the debouncer's output).
- Converts the clean level into single-cycle event pulses: press, release, short press, long press and double click.
- Keeps a wrapping press counter.
- Feeds the control/UI logic, which must never see raw or level-based button signals.

Parameters:
long_press_cycles, 999, held cycles after press_pulse (minus 1) that define a long press; must be >= 1
double_click_cycles, 299, max idle cycles after a short release in which a second press counts as a double click; must be >= 1
repeat_cycles, 199, auto-repeat period in cycles; used only when AUTO_REPEAT_EN is defined
cnt_w, 16, timer width; must hold max(long_press_cycles, double_click_cycles, repeat_cycles)

Ports:
clk  input  1  system clock
rst  input  1  reset; one clock; reset is synchronous and active-high
btn_in  input  1  debounced, already-synchronised button level (1 = pressed)
press_pulse  output  1  one-cycle pulse on each accepted press
release_pulse  output  1  one-cycle pulse on each release
short_press  output  1  one-cycle pulse: single press released before the long threshold, with no second press in the window
long_press  output  1  one-cycle pulse when a hold reaches the long threshold
double_click  output  1  one-cycle pulse on the second press of a double click
repeat_pulse  output  1  auto-repeat pulse; tied 0 without AUTO_REPEAT_EN
press_count  output  8  count of press_pulse events, wraps 255 -> 0

Behaviour:
- Reset values (rst sampled high at a clk edge):
  - All outputs are 0.
  - State is IDLE and timer is 0.
  - btn_q (previous-sample register) loads btn_in, so a button held through reset produces no press.
- Latency and output register: rise = btn_in & ~btn_q and fall = ~btn_in & btn_q, both evaluated at each edge. All outputs are registered; every pulse is valid for exactly the one cycle following the triggering edge.
- State IDLE:
  - rise -> PRESSED, timer = 0, press_pulse.
- State PRESSED:
  - fall -> WAIT_SECOND, timer = 0, release_pulse.
  - btn_in = 1 and timer == long_press_cycles -> LONG_HELD, long_press, timer = 0.
  - Otherwise timer increments.
  - Net timing: long_press asserts long_press_cycles+1 cycles after press_pulse.
- State LONG_HELD:
  - fall -> IDLE, release_pulse. No short_press is ever generated for a long press.
- State WAIT_SECOND:
  - rise -> SECOND_PRESSED, press_pulse and double_click in the same cycle.
  - Else if timer == double_click_cycles -> IDLE, short_press.
  - Otherwise timer increments.
  - Rise and timeout in the same cycle: rise wins (double click, no short_press).
- State SECOND_PRESSED:
  - fall -> IDLE, release_pulse.
  - No long-press detection in this state; the timer is held.
- press_count increments on every press_pulse, including the second press of a double click; modulo 256.
- Unreachable state encodings recover to IDLE on the next edge, with no pulse.
- Reset asserted mid-sequence aborts the sequence immediately; no pending short_press or release is emitted.

Optional Feature:
- Macro: AUTO_REPEAT_EN.
- Defined:
  - In LONG_HELD the timer counts.
  - repeat_pulse asserts when timer == repeat_cycles, then the timer reloads 0. The first repeat is repeat_cycles+1 cycles after long_press.
  - fall in the same cycle as a repeat: release_pulse only.
- Undefined: repeat_pulse is constant 0, repeat_cycles is unused, and the LONG_HELD timer is idle.

Decomposition:
- Shared package button_pkg holds:
  - the state encoding constants (IDLE, PRESSED, LONG_HELD, WAIT_SECOND, SECOND_PRESSED; 3 bits);
  - the press_count width constant (8).
- Natural sub-module: edge_detect (btn_q register, with load-on-reset, plus rise/fall outputs). It is reusable for other debounced inputs.

Test Plan (defaults long_press_cycles=999, double_click_cycles=299 unless stated):
- Short press, no second press: btn_in high 50 cycles then low -> press_pulse, release_pulse, then short_press exactly 300 cycles after release_pulse; press_count = 1.
- Long press: btn_in held 2000 cycles -> long_press 1000 cycles after press_pulse; release_pulse on fall; no short_press; press_count = 1.
- Double click, including the boundary:
  - Press 20, release 100, press 20 -> second press_pulse coincides with double_click, no short_press, press_count = 2.
  - Repeat with the second rise sampled on the exact timeout edge -> double_click still wins.
- Reset:
  - btn_in = 1 throughout rst and after -> no press_pulse until a genuine release/press.
  - rst pulsed in WAIT_SECOND -> no short_press ever emitted.
- Wrap: 256 short presses -> press_count returns to 0.
- AUTO_REPEAT_EN with repeat_cycles=9: hold 1100 cycles -> long_press at 1000, then repeat_pulse every 10 cycles until release; without the macro, repeat_pulse stays 0.

Source files
------------

// File: rtl/button_pkg.sv
// Shared definitions for the button event decoder: FSM state encoding, press counter width, timer helper.
// Pure declarations; no latency or backpressure applies.
package button_pkg;

  localparam int PRESS_CNT_W = 8;

  typedef enum logic [2:0] {
    IDLE           = 3'd0,
    PRESSED        = 3'd1,
    LONG_HELD      = 3'd2,
    WAIT_SECOND    = 3'd3,
    SECOND_PRESSED = 3'd4
  } state_t;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/button_event_decoder_edge_detect.sv
// edge_detect: previous-sample register plus rise/fall strobes for any synchronised, debounced level.
// Strobes are combinational from the current input and last sample; no backpressure.
module edge_detect (
  input  logic clk,
  input  logic sig_i,
  output logic rise_o,
  output logic fall_o
);

  logic sig_q;

  // Loads the live level every edge, including reset edges, so a level held through reset yields no edge.
  always_ff @(posedge clk) begin
    sig_q <= sig_i;
  end

  assign rise_o = sig_i & ~sig_q;
  assign fall_o = ~sig_i & sig_q;

endmodule

// File: rtl/button_event_decoder.sv
// button_event_decoder: debounced level -> registered one-cycle press/release/short/long/double-click pulses,
// one cycle after the sampling edge, no backpressure; auto-repeat pulses only when AUTO_REPEAT_EN is defined.
module button_event_decoder
  import button_pkg::*;
#(
  parameter int unsigned long_press_cycles   = 999,
  parameter int unsigned double_click_cycles = 299,
  parameter int unsigned repeat_cycles       = 199,
  parameter int unsigned cnt_w               = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   btn_in,
  output logic                   press_pulse,
  output logic                   release_pulse,
  output logic                   short_press,
  output logic                   long_press,
  output logic                   double_click,
  output logic                   repeat_pulse,
  output logic [PRESS_CNT_W-1:0] press_count
);

  localparam logic [cnt_w-1:0] LONG_T = cnt_w'(long_press_cycles);
  localparam logic [cnt_w-1:0] DBL_T  = cnt_w'(double_click_cycles);
  localparam logic [cnt_w-1:0] TIMER_MAX =
    cnt_w'(max3(long_press_cycles, double_click_cycles, repeat_cycles));
`ifdef AUTO_REPEAT_EN
  localparam logic [cnt_w-1:0] REP_T  = cnt_w'(repeat_cycles);
`endif

  state_t           state_q;
  logic [cnt_w-1:0] timer_q;
  logic             rise;
  logic             fall;

  edge_detect u_edge (
    .clk    (clk),
    .sig_i  (btn_in),
    .rise_o (rise),
    .fall_o (fall)
  );

  // Saturates at the largest threshold so the timer can never wrap past a compare point.
  function automatic logic [cnt_w-1:0] timer_inc(input logic [cnt_w-1:0] t);
    return (t == TIMER_MAX) ? t : t + cnt_w'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      timer_q       <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      short_press   <= 1'b0;
      long_press    <= 1'b0;
      double_click  <= 1'b0;
      repeat_pulse  <= 1'b0;
      press_count   <= '0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      short_press   <= 1'b0;
      long_press    <= 1'b0;
      double_click  <= 1'b0;
      repeat_pulse  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (rise) begin
            state_q     <= PRESSED;
            timer_q     <= '0;
            press_pulse <= 1'b1;
            press_count <= press_count + PRESS_CNT_W'(1);
          end
        end
        PRESSED: begin
          if (fall) begin
            state_q       <= WAIT_SECOND;
            timer_q       <= '0;
            release_pulse <= 1'b1;
          end else if (btn_in && timer_q == LONG_T) begin
            state_q    <= LONG_HELD;
            timer_q    <= '0;
            long_press <= 1'b1;
          end else begin
            timer_q <= timer_inc(timer_q);
          end
        end
        LONG_HELD: begin
          if (fall) begin
            state_q       <= IDLE;
            timer_q       <= '0;
            release_pulse <= 1'b1;
          end
`ifdef AUTO_REPEAT_EN
          else if (timer_q == REP_T) begin
            timer_q      <= '0;
            repeat_pulse <= 1'b1;
          end else begin
            timer_q <= timer_inc(timer_q);
          end
`endif
        end
        WAIT_SECOND: begin
          // A rise on the timeout edge still counts as the second click.
          if (rise) begin
            state_q      <= SECOND_PRESSED;
            press_pulse  <= 1'b1;
            double_click <= 1'b1;
            press_count  <= press_count + PRESS_CNT_W'(1);
          end else if (timer_q == DBL_T) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            short_press <= 1'b1;
          end else begin
            timer_q <= timer_inc(timer_q);
          end
        end
        SECOND_PRESSED: begin
          if (fall) begin
            state_q       <= IDLE;
            timer_q       <= '0;
            release_pulse <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          timer_q <= '0;
        end
      endcase
    end
  end

endmodule
